// File: rtl/debug_reg_access.sv
// debug_reg_access
//   Debug-host access to a core's register file and PC. A host command is
//   accepted, the core is asked to halt, the access runs once the core
//   acknowledges, and one response beat (or 33 beats for a dump) is returned.
//
//   Handshakes: a transfer happens on a rising clock edge where valid and
//   ready are both 1. A valid producer holds its payload unchanged until that
//   edge; cmd_ready is 1 only while idle (and not in reset), and every rsp_*
//   payload field is 0 whenever rsp_valid is 0.
//
// Ports
//   clock, reset            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake; cmd_op 00 read, 01 write,
//   cmd_op/addr/wdata       10 dump all, 11 resume; addr 0-31 GPR, 32 PC
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/addr/last/err  response payload
//   halt_req, halted        halt request to core and its acknowledge
//   rf_rs_index, rf_rs      combinational GPR read port
//   rf_pc                   current PC
//   rf_we/rd_index/rd       GPR write strobe (one cycle, in EXEC only)
//   rf_pc_we, rf_pc_next    PC write strobe (one cycle, in EXEC only)
//   dbg_state               current FSM state
module debug_reg_access #(
  parameter int HALT_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [5:0]  rsp_addr,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        halt_req,
  input  logic        halted,
  output logic [4:0]  rf_rs_index,
  input  logic [31:0] rf_rs,
  input  logic [31:0] rf_pc,
  output logic        rf_we,
  output logic [4:0]  rf_rd_index,
  output logic [31:0] rf_rd,
  output logic        rf_pc_we,
  output logic [31:0] rf_pc_next,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_EXEC, S_RESP, S_DUMP_LOAD, S_DUMP_SEND, S_RESUME
  } state_t;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DUMP   = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  // wait_cnt counts 0 .. HALT_TIMEOUT-1; the cycle on which it holds the last
  // value without the awaited halted level is the timeout cycle.
  localparam int CW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(HALT_TIMEOUT - 1);

  state_t         state;
  logic [1:0]     op_q;
  logic [5:0]     addr_q;
  logic [31:0]    wdata_q;
  logic [5:0]     dump_cnt;
  logic [CW-1:0]  wait_cnt;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign dbg_state = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= 2'd0;
      addr_q      <= 6'd0;
      wdata_q     <= 32'd0;
      dump_cnt    <= 6'd0;
      wait_cnt    <= '0;
      halt_req    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 32'd0;
      rsp_addr    <= 6'd0;
      rsp_last    <= 1'b0;
      rsp_err     <= 1'b0;
      rf_rs_index <= 5'd0;
      rf_we       <= 1'b0;
      rf_rd_index <= 5'd0;
      rf_rd       <= 32'd0;
      rf_pc_we    <= 1'b0;
      rf_pc_next  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            addr_q   <= cmd_addr;
            wdata_q  <= cmd_wdata;
            wait_cnt <= '0;
            if (cmd_op == OP_RESUME) begin
              halt_req <= 1'b0;
              state    <= S_RESUME;
            end else begin
              halt_req <= 1'b1;
              state    <= S_HALT;
            end
          end
        end

        S_HALT: begin
          if (halted) begin
            if (op_q == OP_DUMP) begin
              dump_cnt    <= 6'd0;
              rf_rs_index <= 5'd0;
              state       <= S_DUMP_LOAD;
            end else begin
              state <= S_EXEC;
              if (op_q == OP_READ) rf_rs_index <= addr_q[4:0];
              // Strobes are raised on entry so they are high for the single
              // EXEC cycle; addr 0 and addr > 32 never strobe.
              if (op_q == OP_WRITE && addr_q != 6'd0 && addr_q < 6'd32) begin
                rf_we       <= 1'b1;
                rf_rd_index <= addr_q[4:0];
                rf_rd       <= wdata_q;
              end
              if (op_q == OP_WRITE && addr_q == 6'd32) begin
                rf_pc_we   <= 1'b1;
                rf_pc_next <= wdata_q;
              end
            end
          end else if (wait_cnt == WAIT_LAST) begin
            halt_req  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_addr  <= addr_q;
            rsp_last  <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_EXEC: begin
          rf_we       <= 1'b0;
          rf_pc_we    <= 1'b0;
          rf_rs_index <= 5'd0;
          rf_rd_index <= 5'd0;
          rf_rd       <= 32'd0;
          rf_pc_next  <= 32'd0;
          rsp_valid   <= 1'b1;
          rsp_addr    <= addr_q;
          rsp_last    <= 1'b1;
          state       <= S_RESP;
          if (addr_q > 6'd32) begin
            rsp_err  <= 1'b1;
            rsp_data <= 32'd0;
          end else begin
            rsp_err <= 1'b0;
            if (op_q == OP_READ) rsp_data <= (addr_q == 6'd32) ? rf_pc : rf_rs;
            else                 rsp_data <= wdata_q;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_addr  <= 6'd0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end

        S_DUMP_LOAD: begin
          rsp_valid   <= 1'b1;
          rsp_data    <= (dump_cnt == 6'd32) ? rf_pc : rf_rs;
          rsp_addr    <= dump_cnt;
          rsp_last    <= (dump_cnt == 6'd32);
          rsp_err     <= 1'b0;
          rf_rs_index <= 5'd0;
          state       <= S_DUMP_SEND;
        end

        S_DUMP_SEND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            rsp_addr  <= 6'd0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            if (dump_cnt == 6'd32) begin
              dump_cnt <= 6'd0;
              state    <= S_IDLE;
            end else begin
              dump_cnt <= dump_cnt + 6'd1;
              // Index wraps to 0 for the PC slot, which reads rf_pc instead.
              rf_rs_index <= dump_cnt[4:0] + 5'd1;
              state       <= S_DUMP_LOAD;
            end
          end
        end

        S_RESUME: begin
          if (!halted || wait_cnt == WAIT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_addr  <= addr_q;
            rsp_last  <= 1'b1;
            rsp_err   <= halted;
            rsp_data  <= 32'd0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_reg_access.sv
// tb_debug_reg_access
//   Drives debug commands against debug_reg_access with a simple register
//   file / core environment, and compares every response beat, strobe count
//   and halt_req level against an abstract model of the command rules.
module tb_debug_reg_access;

  localparam int TO = 4;
  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_DUMP   = 2'b10;
  localparam logic [1:0] OP_RESUME = 2'b11;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [5:0]  rsp_addr;
  logic        rsp_last, rsp_err;
  logic        halt_req, halted;
  logic [4:0]  rf_rs_index;
  logic [31:0] rf_rs, rf_pc;
  logic        rf_we;
  logic [4:0]  rf_rd_index;
  logic [31:0] rf_rd;
  logic        rf_pc_we;
  logic [31:0] rf_pc_next;
  logic [2:0]  dbg_state;

  debug_reg_access #(.HALT_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .halt_req(halt_req), .halted(halted),
    .rf_rs_index(rf_rs_index), .rf_rs(rf_rs), .rf_pc(rf_pc),
    .rf_we(rf_we), .rf_rd_index(rf_rd_index), .rf_rd(rf_rd),
    .rf_pc_we(rf_pc_we), .rf_pc_next(rf_pc_next),
    .dbg_state(dbg_state)
  );

  // environment: register file and PC the DUT reads and writes
  logic [31:0] rf_mem [32];
  logic [31:0] pc_reg;
  int          we_cnt = 0;
  int          pc_we_cnt = 0;
  logic [4:0]  last_we_idx = 5'd0;
  logic [31:0] last_we_data = 32'd0;
  logic [31:0] last_pc_data = 32'd0;
  int          cyc = 0;

  assign rf_rs = (rf_rs_index == 5'd0) ? 32'd0 : rf_mem[rf_rs_index];
  assign rf_pc = pc_reg;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (rf_we) begin
      rf_mem[rf_rd_index] <= rf_rd;
      we_cnt       <= we_cnt + 1;
      last_we_idx  <= rf_rd_index;
      last_we_data <= rf_rd;
    end
    if (rf_pc_we) begin
      pc_reg       <= rf_pc_next;
      pc_we_cnt    <= pc_we_cnt + 1;
      last_pc_data <= rf_pc_next;
    end
  end

  // scoreboard and abstract model
  int          total = 0;
  int          bad = 0;
  logic [39:0] exp_q[$];  // {err, last, addr[5:0], data[31:0]}
  logic [31:0] exp_rf [32];
  logic [31:0] exp_pc;
  int          exp_we = 0;
  int          exp_pc_we = 0;
  logic        exp_halt = 1'b0;

  int halted_mode = 1;  // 0: core never halts, 1: halted tied 1, 2: follows halt_req
  int ready_mode  = 0;  // 0: always ready, 1: toggling, 2: random
  int accept_cyc = 0;
  int rise_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mval(input int a);
    if (a == 0) return 32'd0;
    if (a == 32) return exp_pc;
    return exp_rf[a];
  endfunction

  task automatic model(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] wd);
    logic [5:0] a6;
    if (op == OP_RESUME) begin
      exp_q.push_back({(halted_mode == 1), 1'b1, addr, 32'd0});
      exp_halt = 1'b0;
    end else if (halted_mode == 0) begin
      exp_q.push_back({1'b1, 1'b1, addr, 32'd0});
      exp_halt = 1'b0;
    end else begin
      exp_halt = 1'b1;
      if (op == OP_DUMP) begin
        for (int a = 0; a <= 32; a++) begin
          a6 = 6'(a);
          exp_q.push_back({1'b0, (a == 32), a6, mval(a)});
        end
      end else if (addr > 6'd32) begin
        exp_q.push_back({1'b1, 1'b1, addr, 32'd0});
      end else if (op == OP_READ) begin
        exp_q.push_back({1'b0, 1'b1, addr, mval(int'(addr))});
      end else begin
        exp_q.push_back({1'b0, 1'b1, addr, wd});
        if (addr == 6'd32) begin
          exp_pc = wd;
          exp_pc_we++;
        end else if (addr != 6'd0) begin
          exp_rf[addr[4:0]] = wd;
          exp_we++;
        end
      end
    end
  endtask

  // core / host-ready drivers and response monitor, all on the falling edge.
  // rsp_ready is updated first so the monitor sees the value that the next
  // rising edge will use.
  logic        stalled = 1'b0;
  logic        prev_valid = 1'b0;
  logic [39:0] held = 40'd0;
  logic [39:0] beat;
  logic [39:0] e;

  always @(negedge clock) begin
    case (halted_mode)
      0:       halted = 1'b0;
      1:       halted = 1'b1;
      default: halted = halt_req;
    endcase
    case (ready_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ~rsp_ready;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    beat = {rsp_err, rsp_last, rsp_addr, rsp_data};
    if (reset) begin
      stalled    = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (!rsp_valid) begin
        check("rsp_quiet", 64'(beat), 64'd0);
        stalled = 1'b0;
      end else begin
        if (!prev_valid) rise_cyc = cyc;
        if (stalled) check("rsp_hold", 64'(beat), 64'(held));
        if (rsp_ready) begin
          check("rsp_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_beat", 64'(beat), 64'(e));
          end
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = beat;
        end
      end
      prev_valid = rsp_valid;
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [31:0] wd);
    int n;
    n = 0;
    model(op, addr, wd);
    @(negedge clock);
    while (!cmd_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    accept_cyc = cyc + 1;
    rise_cyc   = -1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
    @(negedge clock);
    check("halt_req", 64'(halt_req), 64'(exp_halt));
    check("we_count", 64'(we_cnt), 64'(exp_we));
    check("pc_we_count", 64'(pc_we_cnt), 64'(exp_pc_we));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          r;
    int          n;
    logic [1:0]  op;
    logic [5:0]  addr;
    logic [31:0] wd;

    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 6'd0;
    cmd_wdata = 32'd0;
    halted    = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = $urandom;
      exp_rf[i] = rf_mem[i];
    end
    pc_reg = $urandom;
    exp_pc = pc_reg;

    // reset state
    #1 reset = 1'b1;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_halt_req", 64'(halt_req), 64'd0);
    check("rst_strobes", 64'({rf_we, rf_pc_we, rf_rs_index, rf_rd_index}), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_release_ready", 64'(cmd_ready), 64'd1);
    check("dbg_state_idle", 64'(dbg_state), 64'd0);

    // write GPR 5, halted already 1: two-edge response latency
    halted_mode = 1;
    ready_mode  = 0;
    send_cmd(OP_WRITE, 6'd5, 32'hDEADBEEF);
    drain();
    check("wr5_latency", 64'(rise_cyc - accept_cyc), 64'd2);
    check("wr5_index", 64'(last_we_idx), 64'd5);
    check("wr5_data", 64'(last_we_data), 64'hDEADBEEF);

    // write / read x0
    send_cmd(OP_WRITE, 6'd0, 32'h1234);
    drain();
    send_cmd(OP_READ, 6'd0, 32'd0);
    drain();

    // PC write, PC read back, invalid address
    send_cmd(OP_WRITE, 6'd32, 32'h100);
    drain();
    check("pc_next", 64'(last_pc_data), 64'h100);
    send_cmd(OP_READ, 6'd32, 32'd0);
    drain();
    send_cmd(OP_READ, 6'd40, 32'd0);
    drain();
    send_cmd(OP_WRITE, 6'd63, 32'hFFFF_0000);
    drain();

    // halt timeout
    halted_mode = 0;
    send_cmd(OP_READ, 6'd3, 32'd0);
    drain();
    check("timeout_latency", 64'(rise_cyc - accept_cyc), 64'(TO));

    // resume: core leaves halt, then core stuck halted
    halted_mode = 2;
    send_cmd(OP_READ, 6'd5, 32'd0);
    drain();
    send_cmd(OP_RESUME, 6'd0, 32'd0);
    drain();
    halted_mode = 1;
    send_cmd(OP_RESUME, 6'd7, 32'd0);
    drain();

    // full dump with toggling ready
    halted_mode = 1;
    ready_mode  = 1;
    send_cmd(OP_DUMP, 6'd0, 32'd0);
    drain();

    // randomized command mix
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      halted_mode = (r == 0) ? 0 : ((r < 6) ? 1 : 2);
      ready_mode  = $urandom_range(0, 2);
      op = 2'($urandom_range(0, 3));
      if (op == OP_DUMP && $urandom_range(0, 3) != 0) op = OP_READ;
      addr = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(33, 63))
                                         : 6'($urandom_range(0, 32));
      wd = $urandom;
      send_cmd(op, addr, wd);
      drain();
    end

    // reset during dump beat 10
    halted_mode = 1;
    ready_mode  = 1;
    send_cmd(OP_DUMP, 6'd0, 32'd0);
    n = 0;
    while (n < 400 && !(rsp_valid && rsp_addr == 6'd10)) begin
      @(negedge clock);
      n++;
    end
    check("dump_beat10_seen", 64'(rsp_valid && rsp_addr == 6'd10), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rsp", 64'({rsp_valid, rsp_last, rsp_err, rsp_addr, rsp_data}), 64'd0);
    check("mid_rst_halt_req", 64'(halt_req), 64'd0);
    check("mid_rst_strobes", 64'({rf_we, rf_pc_we, rf_rs_index, rf_rd_index}), 64'd0);
    check("mid_rst_wdata", 64'({rf_rd, rf_pc_next}), 64'd0);
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clock);
    exp_q.delete();
    exp_halt = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_ready", 64'(cmd_ready), 64'd1);
    ready_mode = 0;
    send_cmd(OP_READ, 6'd5, 32'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_reg_access.md
DEBUG_REG_ACCESS -- requirements
Module: debug_reg_access

Interface
REQ-001 Parameter HALT_TIMEOUT, default 255: maximum cycles to wait for halted to change before aborting with an error.
REQ-002 clock  in  1  single clock for the block; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  debug host command present.
REQ-005 cmd_ready  out  1  block accepts a command; a command transfers when cmd_valid && cmd_ready at a rising edge.
REQ-006 cmd_op  in  2  00 read, 01 write, 10 dump all, 11 resume.
REQ-007 cmd_addr  in  6  0-31 GPR x0-x31, 32 PC, 33-63 invalid.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid / rsp_ready  out / in  1 / 1  response handshake; a beat transfers when both are high at a rising edge.
REQ-010 rsp_data  out  32, rsp_addr  out  6, rsp_last  out  1, rsp_err  out  1  response payload.
REQ-011 halt_req  out  1  request to the core to stop; halted  in  1  core stopped acknowledge.
REQ-012 rf_rs_index  out  5, rf_rs  in  32  GPR read port (combinational read; index 0 returns 0).
REQ-013 rf_pc  in  32  current PC value.
REQ-014 rf_we  out  1, rf_rd_index  out  5, rf_rd  out  32  GPR write port, written on the rising edge where rf_we=1.
REQ-015 rf_pc_we  out  1, rf_pc_next  out  32  PC write port.

Function
REQ-016 States IDLE, HALT, EXEC, RESP, DUMP_LOAD, DUMP_SEND, RESUME; cmd_ready=1 only in IDLE.
REQ-017 On acceptance, op/addr/wdata are latched; read/write/dump go to HALT and set halt_req=1; resume goes to RESUME and clears halt_req.
REQ-018 halt_req is sticky: it stays 1 across commands until a resume or a halt timeout.
REQ-019 HALT: if halted=1, go to EXEC (read/write) or DUMP_LOAD (dump, counter=0); otherwise increment the wait counter.
REQ-020 With halted already 1, rsp_valid rises on the second rising edge after the accepting edge.
REQ-021 Timeout: after HALT_TIMEOUT cycles in HALT or RESUME without the expected halted level, go to RESP with rsp_err=1 and rsp_data=0; halt_req=0 in RESP.
REQ-022 EXEC lasts exactly one cycle. Read: rf_rs_index=addr[4:0]; capture rf_rs, or rf_pc for addr 32.
REQ-023 Write to addr 1-31: rf_we=1 for exactly one cycle with rf_rd_index=addr[4:0] and rf_rd=wdata.
REQ-024 Write to addr 32: rf_pc_we=1 for one cycle with rf_pc_next=wdata.
REQ-025 Write to addr 0: no strobe; response rsp_err=0.
REQ-026 Write response: rsp_data echoes wdata.
REQ-027 addr 33-63 (read or write): no strobe; response rsp_err=1, rsp_data=0.
REQ-028 RESP: rsp_valid=1 with rsp_addr=addr and rsp_last=1; payload stable until rsp_ready; then go to IDLE.
REQ-029 DUMP_LOAD: capture the value at counter (0-31 GPR, 32 PC), then go to DUMP_SEND.
REQ-030 DUMP_SEND: rsp_valid=1, rsp_addr=counter, rsp_last=(counter==32), rsp_err=0; payload held while stalled.
REQ-031 DUMP_SEND on handshake: counter 32 goes to IDLE, otherwise counter+1 and DUMP_LOAD; a full dump is 33 beats.
REQ-032 RESUME: wait for halted=0, then RESP with rsp_err=0 and rsp_data=0.
REQ-033 When not in EXEC or DUMP_LOAD, rf_rs_index=0.
REQ-034 rf_we and rf_pc_we are never 1 outside EXEC.
REQ-035 Idle outputs: rf_rd, rf_rd_index and rf_pc_next are 0.
REQ-036 rsp_* are 0 whenever rsp_valid=0.

Reset
REQ-037 On reset=1, asynchronously: state=IDLE, counters=0, halt_req=0, rsp_valid/rsp_last/rsp_err=0, rsp_data/rsp_addr=0, rf_we=rf_pc_we=0, rf_rs_index/rf_rd_index=0, rf_rd=rf_pc_next=0; cmd_ready=1 after release.
REQ-038 Reset mid-operation aborts with no further strobes; writes already strobed remain.

Verification
REQ-039 halted tied 1; write addr 5, data 0xDEADBEEF -> one-cycle rf_we, rf_rd_index=5, rf_rd=0xDEADBEEF; response err=0, data=0xDEADBEEF, last=1.
REQ-040 Write addr 0, data 0x1234 -> no rf_we, err=0; then read addr 0 -> rsp_data=0.
REQ-041 Write addr 32, data 0x100 -> rf_pc_we pulse with rf_pc_next=0x100; read addr 40 -> err=1, data=0, no strobes.
REQ-042 HALT_TIMEOUT=4, halted held 0, read addr 3 -> response err=1 after 4 HALT cycles; halt_req=0.
REQ-043 Dump with rsp_ready toggling 1/0 -> 33 beats with addr 0..32 in order, last only on addr 32, data stable while stalled, values match the register model.
REQ-044 Reset asserted during dump beat 10 -> all outputs 0 immediately; cmd_ready=1 after release; no rf_we seen.
